id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32 core. Sits directly downstream of the decode-stage control unit and register file.
- Captures the decoded control bundle, operands, immediate, funct bits and register indices on each clock, and presents them to the EX stage.
- Supports stall (hold) and flush (bubble insertion) for the hazard unit and branch resolution.
- Keeps a bubble counter and a valid-instruction counter for performance debug.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register index width
- CNT_W, 32, performance counter width

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold every stage register this cycle
- flush_i  in  1  replace the incoming instruction with a bubble
- valid_i  in  1  decode stage holds a real instruction
- RegWrite_i, MemReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in  1 each  control bundle from the control unit
- ALUOp_i  in  2  ALU op class from the control unit
- RS1data_i, RS2data_i  in  DATA_W  register file read data
- Imm_i  in  DATA_W  sign-extended immediate
- Funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW  register indices
- RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o  out  1 each  registered control bundle
- ALUOp_o  out  2  registered ALU op class
- RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o  out  as inputs  registered payload
- valid_o  out  1  EX stage holds a real instruction
- bubble_cnt_o  out  CNT_W  bubbles entered into EX
- inst_cnt_o  out  CNT_W  valid instructions entered into EX

Behaviour:
- Reset (rst_i=0, asynchronous): every output is 0, including counters. State stays at 0 while reset is held. Release takes effect at the next rising edge.
- Priority at each rising edge: flush_i > stall_i > normal load.
- Normal load (flush_i=0, stall_i=0): all outputs take the input values, latency 1 cycle. valid_o <= valid_i.
- Bubble load: normal load with valid_i=0 forces RegWrite_o, MemRead_o, MemWrite_o and Branch_o to 0. Other fields still load.
- Stall (stall_i=1, flush_i=0): every output and both counters hold their value.
- Flush (flush_i=1, regardless of stall_i): the entire control bundle, ALUOp_o and valid_o go to 0. All payload fields go to 0.
- Bubble output state: a flushed bubble decodes as no side effects, with no register write, memory access or branch.
- bubble_cnt_o increments by 1 on every edge that loads a bubble, either a flush or a normal load with valid_i=0. It does not count stall cycles.
- inst_cnt_o increments by 1 on every normal load with valid_i=1.
- Both counters wrap modulo 2^CNT_W and never saturate.
- flush_i and stall_i asserted in the same cycle: a flush occurs and bubble_cnt_o increments once.
- Reset asserted mid-stall or mid-flush: outputs clear immediately, and no pending stall or flush survives.
- No combinational path from any input to any output.

Decomposition:
- Shared package (cpu_pkg): ALUOp encodings (ALUOP_LDST=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10), opcode constants, and a packed ctrl_t bundle {RegWrite, MemReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp}.
- Same package holds the CTRL_NOP constant, all zeros.
- One sub-module, perf_counter (enable, wrap-around, async active-low clear), is instantiated twice.
- The register bank itself stays in id_ex_reg.

Test Plan:
- Reset: hold rst_i=0 with random inputs and toggle the clock → all outputs 0. Release reset and apply one R-type load (RegWrite_i=1, ALUOp_i=2'b10, RS1data_i=32'h1234) → next cycle RegWrite_o=1, ALUOp_o=2'b10, RS1data_o=32'h1234, valid_o=1, inst_cnt_o=1.
- Stall: load a lw (MemRead_i=1, Imm_i=32'h10), then stall_i=1 for 3 cycles with different inputs → outputs stay at the lw values and counters unchanged. After release the new instruction appears 1 cycle later.
- Flush: with a sw in EX (MemWrite_o=1), assert flush_i=1 while presenting a beq → MemWrite_o=0, Branch_o=0, valid_o=0, RDaddr_o=0, bubble_cnt_o increments by 1.
- Flush and stall together: flush_i=1 and stall_i=1 in the same cycle → bubble inserted, not a hold, and bubble_cnt_o increments by exactly 1.
- Invalid input: valid_i=0 with RegWrite_i=1 and MemWrite_i=1 → RegWrite_o=0, MemWrite_o=0, bubble_cnt_o increments, inst_cnt_o unchanged.
- Wrap-around: force inst_cnt_o to 32'hFFFFFFFF, then one valid load → inst_cnt_o=0. Assert reset mid-stall → immediate clear without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared RV32 core encodings and the ID/EX control bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       RegWrite;
    logic       MemReg;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic       Branch;
    logic [1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_perf_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_counter : wrap-around event counter, async active-low clear     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_reg : ID/EX pipeline register with stall, flush, perf counters |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        Funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              RegWrite_o,
  output logic              MemReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [9:0]        Funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  inst_cnt_o
);

  ctrl_t              ctrl_in;
  ctrl_t              ctrl_q,  ctrl_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  rs1_q,   rs1_d;
  logic [DATA_W-1:0]  rs2_q,   rs2_d;
  logic [DATA_W-1:0]  imm_q,   imm_d;
  logic [9:0]         funct_q, funct_d;
  logic [REG_AW-1:0]  a1_q,    a1_d;
  logic [REG_AW-1:0]  a2_q,    a2_d;
  logic [REG_AW-1:0]  rd_q,    rd_d;
  logic               bubble_en;
  logic               inst_en;

  always_comb begin
    ctrl_in          = CTRL_NOP;
    ctrl_in.RegWrite = RegWrite_i;
    ctrl_in.MemReg   = MemReg_i;
    ctrl_in.MemRead  = MemRead_i;
    ctrl_in.MemWrite = MemWrite_i;
    ctrl_in.ALUSrc   = ALUSrc_i;
    ctrl_in.Branch   = Branch_i;
    ctrl_in.ALUOp    = ALUOp_i;

    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    rd_d    = rd_q;

    // Flush outranks stall so a squashed instruction can never be held in EX.
    if (flush_i) begin
      ctrl_d  = CTRL_NOP;
      valid_d = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
      imm_d   = '0;
      funct_d = '0;
      a1_d    = '0;
      a2_d    = '0;
      rd_d    = '0;
    end else if (!stall_i) begin
      ctrl_d  = ctrl_in;
      valid_d = valid_i;
      rs1_d   = RS1data_i;
      rs2_d   = RS2data_i;
      imm_d   = Imm_i;
      funct_d = Funct_i;
      a1_d    = RS1addr_i;
      a2_d    = RS2addr_i;
      rd_d    = RDaddr_i;
      if (!valid_i) begin
        ctrl_d.RegWrite = 1'b0;
        ctrl_d.MemRead  = 1'b0;
        ctrl_d.MemWrite = 1'b0;
        ctrl_d.Branch   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      funct_q <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      funct_q <= funct_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      rd_q    <= rd_d;
    end
  end

  assign bubble_en = flush_i | (~stall_i & ~valid_i);
  assign inst_en   = ~flush_i & ~stall_i & valid_i;

  perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (inst_en),
    .cnt_o (inst_cnt_o)
  );

  assign RegWrite_o = ctrl_q.RegWrite;
  assign MemReg_o   = ctrl_q.MemReg;
  assign MemRead_o  = ctrl_q.MemRead;
  assign MemWrite_o = ctrl_q.MemWrite;
  assign ALUSrc_o   = ctrl_q.ALUSrc;
  assign Branch_o   = ctrl_q.Branch;
  assign ALUOp_o    = ctrl_q.ALUOp;
  assign RS1data_o  = rs1_q;
  assign RS2data_o  = rs2_q;
  assign Imm_o      = imm_q;
  assign Funct_o    = funct_q;
  assign RS1addr_o  = a1_q;
  assign RS2addr_o  = a2_q;
  assign RDaddr_o   = rd_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire
